normalization: RTL and testbench

//  Converts the signed fixed-point accumulator sum from the FP MAC datapath back to
//  FP16 (1 sign, 5 exp, 10 mant). Sign-magnitude split, leading-one detect, left-

---
 rtl/normalization.sv | 141 ++++++++++++++
 tb/tb_normalization.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/normalization.sv
// Fixed-point accumulator to FP16 converter: sign/magnitude split, leading-one
// detect, left-normalise and exponent re-bias, behind a stallable valid/ready pipe.
module normalization #(
    parameter int ACC_W  = 20,
    parameter int FRAC_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] acc_sum,
    input  logic [4:0]       exp_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      fp_out,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = $clog2(ACC_W);
    localparam logic [PW-1:0] TOP_IDX = PW'(ACC_W - 1);

    function automatic logic [PW-1:0] lead_one(input logic [ACC_W-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    logic             stall_s;
    logic             v1_q, v2_q, v3_q, out_valid_q;
    logic             sign1_q, sign2_q, sign3_q;
    logic [ACC_W-1:0] mag1_d, mag1_q, mag2_q;
    logic [4:0]       exp1_q, exp2_q;
    logic             zero2_d, zero2_q, zero3_q;
    logic [PW-1:0]    p2_d, p2_q;
    logic [PW-1:0]    shift_s;
    logic [ACC_W-1:0] norm_s;
    logic signed [7:0] e3_d, e3_q;
    logic [9:0]       mant3_d, mant3_q;
    logic [15:0]      fp_d, fp_q;
    logic             ovf_d, ovf_q, unf_d, unf_q;

    // A held output blocks the whole pipe; nothing moves until it is taken.
    assign stall_s   = out_valid_q && !out_ready;
    assign in_ready  = !stall_s;
    assign out_valid = out_valid_q;
    assign fp_out    = fp_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    // Stage 1 magnitude; the most-negative input maps to 2^(ACC_W-1) unsigned.
    always_comb begin
        mag1_d = acc_sum[ACC_W-1] ? (-acc_sum) : acc_sum;
    end

    // Stage 2 leading-one detect and zero flag.
    always_comb begin
        p2_d    = lead_one(mag1_q);
        zero2_d = (mag1_q == '0);
    end

    // Stage 3 exponent re-bias and left-normalised mantissa (truncating).
    always_comb begin
        shift_s = TOP_IDX - p2_q;
        norm_s  = mag2_q << shift_s;
        mant3_d = norm_s[ACC_W-2 -: 10];
        e3_d    = $signed({3'b000, exp2_q}) + $signed({{(8-PW){1'b0}}, p2_q}) - 8'(FRAC_W);
    end

    // Output classification: zero, saturate to inf, flush to zero, or normal.
    always_comb begin
        if (zero3_q) begin
            fp_d  = 16'h0000;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (e3_q >= 8'sd31) begin
            fp_d  = {sign3_q, 5'h1F, 10'h000};
            ovf_d = 1'b1;
            unf_d = 1'b0;
        end else if (e3_q <= 8'sd0) begin
            fp_d  = {sign3_q, 15'h0000};
            ovf_d = 1'b0;
            unf_d = 1'b1;
        end else begin
            fp_d  = {sign3_q, e3_q[4:0], mant3_q};
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // Pipeline registers; all ranks advance together when not stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            sign3_q     <= 1'b0;
            mag1_q      <= '0;
            mag2_q      <= '0;
            exp1_q      <= 5'd0;
            exp2_q      <= 5'd0;
            zero2_q     <= 1'b0;
            zero3_q     <= 1'b0;
            p2_q        <= '0;
            e3_q        <= 8'sd0;
            mant3_q     <= 10'd0;
            fp_q        <= 16'h0000;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (!stall_s) begin
            v1_q        <= in_valid;
            sign1_q     <= acc_sum[ACC_W-1];
            mag1_q      <= mag1_d;
            exp1_q      <= exp_max;
            v2_q        <= v1_q;
            sign2_q     <= sign1_q;
            mag2_q      <= mag1_q;
            exp2_q      <= exp1_q;
            zero2_q     <= zero2_d;
            p2_q        <= p2_d;
            v3_q        <= v2_q;
            sign3_q     <= sign2_q;
            zero3_q     <= zero2_q;
            e3_q        <= e3_d;
            mant3_q     <= mant3_d;
            out_valid_q <= v3_q;
            fp_q        <= fp_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

endmodule

// File: tb/tb_normalization.sv
// Scoreboard bench for normalization: directed vectors with hand-computed FP16
// results, back-to-back flow with a downstream stall, and mid-flight reset.
module tb_normalization;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] acc_sum;
    logic [4:0]  exp_max;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] fp_out;
    logic        ovf;
    logic        unf;

    normalization #(.ACC_W(20), .FRAC_W(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .acc_sum(acc_sum), .exp_max(exp_max),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp_out(fp_out), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fp;
        logic        ovf;
        logic        unf;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    int   stall_seen = 0;

    // Directed vectors: acc, exp_max, expected fp_out/ovf/unf (hand-computed).
    logic [19:0] va [14] = '{20'h04000, 20'hFC000, 20'h06000, 20'h80000, 20'h10000,
                             20'h00400, 20'h00000, 20'h00001, 20'hF0000, 20'hFFC00,
                             20'h04000, 20'h08000, 20'h02000, 20'h07FFF};
    logic [4:0]  ve [14] = '{5'd15, 5'd15, 5'd15, 5'd10, 5'd30,
                             5'd1,  5'd20, 5'd28, 5'd30, 5'd1,
                             5'd30, 5'd30, 5'd1,  5'd15};
    logic [15:0] vf [14] = '{16'h3C00, 16'hBC00, 16'h3E00, 16'hBC00, 16'h7C00,
                             16'h0000, 16'h0000, 16'h3800, 16'hFC00, 16'h8000,
                             16'h7800, 16'h7C00, 16'h0000, 16'h3FFF};
    logic        vo [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b0, 1'b0};
    logic        vu [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: handshake rule, stall stability, and scoreboard pops on transfer.
    initial begin : monitor
        logic        prev_stall;
        logic [15:0] prev_fp;
        logic        prev_ovf, prev_unf;
        exp_t        e;
        prev_stall = 1'b0;
        prev_fp = 16'h0; prev_ovf = 1'b0; prev_unf = 1'b0;
        forever begin
            @(negedge clk);
            check("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'b0, out_valid}, 32'd1);
                    check("hold_data", {14'b0, ovf, unf, fp_out}, {14'b0, prev_ovf, prev_unf, prev_fp});
                end
                if (out_valid && !out_ready) stall_seen++;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        check("unexpected_out", {16'b0, fp_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("fp_out", {16'b0, fp_out}, {16'b0, e.fp});
                        check("flags", {30'b0, ovf, unf}, {30'b0, e.ovf, e.unf});
                        if (e.chk_lat) check("latency", cyc - e.acc_cyc, 32'd3);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_fp = fp_out; prev_ovf = ovf; prev_unf = unf;
            end
        end
    end

    // Drive one vector; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send(input int idx, input bit lat);
        bit   ok;
        exp_t e;
        in_valid = 1'b1;
        acc_sum  = va[idx];
        exp_max  = ve[idx];
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        e.fp = vf[idx]; e.ovf = vo[idx]; e.unf = vu[idx];
        e.acc_cyc = cyc + 1; e.chk_lat = lat;
        if (ok) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("drain", sb.size(), 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; acc_sum = 20'h0; exp_max = 5'd0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out", {14'b0, ovf, unf, fp_out}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Isolated item for latency, then the remaining vectors back-to-back.
        send(0, 1'b1);
        drain();
        for (int i = 1; i < 14; i++) send(i, 1'b0);
        drain();

        // Eight back-to-back items with downstream not ready for cycles 4..6.
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, 1'b0);
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    out_ready = !(c >= 4 && c <= 6);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_seen", {31'b0, stall_seen > 0}, 32'd1);

        // Reset with three items in flight and one already presented.
        for (int i = 0; i < 3; i++) send(i + 3, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b0;
        sb.delete();
        n_out = 0;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out", {14'b0, ovf, unf, fp_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_out", n_out, 32'd0);

        // Pipe still works after the reset.
        send(13, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
